lfsr_stream: RTL and testbench
==============================

# lfsr_stream

Parametrised Fibonacci LFSR pseudo-random generator. It has a runtime seed load and zero-seed protection. Output bits are packed into OUT_W-bit words and delivered on a valid/ready stream with backpressure. A wrap pulse marks each completed period. It serves as the shared stimulus and noise source for the lab datapaths, and supersedes the fixed 8-bit generator.

## Interface

- WIDTH, 8: LFSR state width, 3..32.
- TAPS, 8'hB8: feedback mask, WIDTH bits. Bit i set means state[i] feeds the XOR. Bit WIDTH-1 must be set.
  - The default is x^8+x^6+x^5+x^4+1, which is maximal length with period 255.
- SEED, 1: reset and fallback seed, WIDTH bits. Must be nonzero.
- OUT_W, 4: output word width, 1..32.

Ports:

- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance request; one LFSR step per cycle when allowed.
- load  in  1  load seed_in this cycle.
- seed_in  in  WIDTH  seed value for load.
- state  out  WIDTH  current LFSR register.
- out_data  out  OUT_W  packed output word.
- out_valid  out  1  out_data holds an unconsumed word.
- out_ready  in  1  consumer accepts out_data when out_valid=1.
- wrap  out  1  one-cycle pulse: the state just returned to the active seed.
- seed_zero  out  1  one-cycle pulse: the load was rejected because seed_in=0 and SEED was used instead.

## Operation

- **Feedback and next state.**
  - fb = XOR-reduce(state & TAPS).
  - next = {state[WIDTH-2:0], fb}.
  - fb is also the output bit of that step.
- **Step enable.** step = en & ~load & ~stall.
- **Stall.** stall = (cnt == OUT_W-1) & out_valid & ~out_ready. The LFSR and the accumulator freeze; no bits are lost.
- **Accumulator.** cnt counts 0..OUT_W-1.
  - On a step with cnt < OUT_W-1: acc <= {acc, fb}, shift left with fb into the LSB, and cnt++.
  - On a step with cnt == OUT_W-1:
    - out_data <= {acc[OUT_W-2:0], fb}. For OUT_W=1, out_data <= fb.
    - out_valid <= 1.
    - cnt <= 0.
  - The first generated bit ends up as the word's MSB.
- **Handshake.**
  - A transfer occurs when out_valid & out_ready.
  - After a transfer, out_valid clears unless a new word completes in the same cycle; then it stays 1 with the new data.
  - out_data is stable while out_valid=1 and out_ready=0.
- **Load.** Load has priority over en.
  - Active seed: seed_reg <= (seed_in==0) ? SEED : seed_in, and state <= the same value.
  - The accumulator is discarded: cnt <= 0.
  - out_valid <= 0, so a pending word is dropped.
  - seed_zero pulses the next cycle when seed_in==0.
- **Wrap.** wrap <= step & (next == seed_reg).
- **Lockup.** The all-zero state is unreachable: reset and load never install zero, and XOR feedback cannot reach it from a nonzero state.
- **Reset values.**
  - state = SEED and seed_reg = SEED.
  - acc = 0, cnt = 0.
  - out_data = 0, out_valid = 0.
  - wrap = 0, seed_zero = 0.

## Timing

- The state is registered; state reflects a step one cycle after en is sampled.
- Word latency: out_valid rises in the cycle after the OUT_W-th accepted step.
- Free-running throughput: one word per OUT_W cycles when en=1 and out_ready=1.
- wrap and seed_zero are registered single-cycle pulses, aligned with the cycle in which state shows the new value.
- If rst and load are asserted in the same cycle, rst wins.
- When load arrives mid-word with out_valid=1, the word is lost. The consumer must not rely on it.
- If load and a transfer (out_valid & out_ready) coincide, the transfer counts as completed, and out_valid is 0 next cycle.

## Test plan

- **Reset and first steps.** Defaults; reset, then en=1, out_ready=1.
  - state must be 01, 02, 04, 08, 11 on successive cycles.
  - The first word out_data=4'h1 appears with out_valid=1 one cycle after the 4th step.
- **Full period.** Defaults; en=1 continuously.
  - wrap pulses exactly once every 255 steps.
  - state never equals 0.
  - All 255 nonzero values are visited once per period.
- **Backpressure.** Hold out_ready=0 with en=1.
  - After the first word, the LFSR advances 3 more steps, then freezes with cnt=3 and out_data held at 4'h1.
  - Raise out_ready for one cycle: the next word 4'h? (the model value) is presented, with no gap or lost bit versus the free-running model.
- **Zero seed.** load=1 with seed_in=0.
  - state=SEED=01 and seed_zero pulses once.
  - load with seed_in=8'hA5: state=A5, and wrap occurs 255 steps later.
- **Load mid-word.** With cnt=2 and out_valid=1, pulse load with seed_in=8'h3C.
  - out_valid=0 next cycle and cnt=0.
  - The next word is built only from the new sequence, starting at 3C.
- **Parameter sweep.**
  - WIDTH=16, TAPS=16'hB400, OUT_W=8: period 65535 with wrap spacing checked.
  - OUT_W=1: out_data equals fb every step.

Source files
------------

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR noise source: runtime seed load with zero-seed fallback,
// output bits packed MSB-first into OUT_W-bit words on a valid/ready stream.
module lfsr_stream #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 'hB8,
    parameter logic [WIDTH-1:0] SEED  = 'd1,
    parameter int               OUT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed_in,
    output logic [WIDTH-1:0] state,
    output logic [OUT_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             wrap,
    output logic             seed_zero
);

    localparam int              CNT_W    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OUT_W - 1);

    logic [WIDTH-1:0] state_q, state_d;
    logic [WIDTH-1:0] seed_q, seed_d;
    logic [OUT_W-1:0] acc_q, acc_d;
    logic [OUT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             wrap_q, wrap_d;
    logic             zero_q, zero_d;

    logic             fb;
    logic             last;
    logic             stall;
    logic             step;
    logic [WIDTH-1:0] next_state;
    logic [WIDTH-1:0] seed_eff;
    logic [OUT_W-1:0] acc_shift;

    always_comb begin
        fb         = ^(state_q & TAPS);
        next_state = {state_q[WIDTH-2:0], fb};
        last       = (cnt_q == CNT_LAST);
        // Only a completed word with nowhere to go blocks the generator.
        stall      = last & valid_q & ~out_ready;
        step       = en & ~load & ~stall;
        // Truncating cast also covers OUT_W=1, where the word is just fb.
        acc_shift  = OUT_W'({acc_q, fb});
        seed_eff   = (seed_in == '0) ? SEED : seed_in;

        state_d = state_q;
        seed_d  = seed_q;
        acc_d   = acc_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        wrap_d  = 1'b0;
        zero_d  = 1'b0;

        if (load) begin
            seed_d  = seed_eff;
            state_d = seed_eff;
            acc_d   = '0;
            cnt_d   = '0;
            valid_d = 1'b0;
            zero_d  = (seed_in == '0);
        end else begin
            if (valid_q && out_ready) begin
                valid_d = 1'b0;
            end
            if (step) begin
                state_d = next_state;
                wrap_d  = (next_state == seed_q);
                if (last) begin
                    data_d  = acc_shift;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    acc_d = acc_shift;
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEED;
            seed_q  <= SEED;
            acc_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seed_q  <= seed_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            zero_q  <= zero_d;
        end
    end

    assign state     = state_q;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
    assign seed_zero = zero_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Bench for lfsr_stream: directed scenarios plus a randomized run against a
// bit-queue reference model; also covers a 16-bit/8-bit-word and a 1-bit-word build.
module tb_lfsr_stream;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // default build
    logic       rst = 1'b1, en = 1'b0, load = 1'b0, out_ready = 1'b0;
    logic [7:0] seed_in = 8'h00;
    logic [7:0] state;
    logic [3:0] out_data;
    logic       out_valid, wrap, seed_zero;

    // 16-bit state, 8-bit words
    logic        rst16 = 1'b1, en16 = 1'b0, load16 = 1'b0, ready16 = 1'b0;
    logic [15:0] seed16 = 16'h0000;
    logic [15:0] state16;
    logic [7:0]  data16;
    logic        valid16, wrap16, sz16;

    // 1-bit words
    logic       rst1 = 1'b1, en1 = 1'b0, load1 = 1'b0, rdy1 = 1'b0;
    logic [7:0] seed1 = 8'h00;
    logic [7:0] state1;
    logic [0:0] data1;
    logic       valid1, wrap1, sz1;

    lfsr_stream u8 (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed_in(seed_in),
        .state(state), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .wrap(wrap), .seed_zero(seed_zero)
    );

    lfsr_stream #(.WIDTH(16), .TAPS(16'hB400), .SEED(16'h0001), .OUT_W(8)) u16 (
        .clk(clk), .rst(rst16), .en(en16), .load(load16), .seed_in(seed16),
        .state(state16), .out_data(data16), .out_valid(valid16),
        .out_ready(ready16), .wrap(wrap16), .seed_zero(sz16)
    );

    lfsr_stream #(.WIDTH(8), .TAPS(8'hB8), .SEED(8'h01), .OUT_W(1)) u1 (
        .clk(clk), .rst(rst1), .en(en1), .load(load1), .seed_in(seed1),
        .state(state1), .out_data(data1), .out_valid(valid1),
        .out_ready(rdy1), .wrap(wrap1), .seed_zero(sz1)
    );

    // ---------------- reference helpers ----------------
    function automatic logic [7:0] nxt8(input logic [7:0] s);
        logic b;
        b = ($countones(s & 8'hB8) % 2) != 0;
        return {s[6:0], b};
    endfunction

    function automatic logic [15:0] nxt16(input logic [15:0] s);
        logic b;
        b = ($countones(s & 16'hB400) % 2) != 0;
        return {s[14:0], b};
    endfunction

    function automatic logic [7:0] st8(input logic [7:0] s0, input int n);
        logic [7:0] s;
        s = s0;
        for (int k = 0; k < n; k++) s = nxt8(s);
        return s;
    endfunction

    // j-th 4-bit word (1-based) generated from seed s0, first bit as MSB
    function automatic logic [3:0] word8(input logic [7:0] s0, input int j);
        logic [7:0] s;
        logic [3:0] w;
        s = st8(s0, 4 * (j - 1));
        w = 4'h0;
        for (int k = 0; k < 4; k++) begin
            s = nxt8(s);
            w = {w[2:0], s[0]};
        end
        return w;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic rst8();
        rst = 1'b1; en = 1'b0; load = 1'b0; out_ready = 1'b0; seed_in = 8'h00;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1; load = 1'b1; seed_in = 8'hA5; en = 1'b1; out_ready = 1'b1;
        cyc();
        cyc();
        total++; if (state !== 8'h01) begin bad++; $display("FAIL reset_state: got %h want 01", state); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 4'h0) begin bad++; $display("FAIL reset_data: got %h want 0", out_data); end
        total++; if (wrap !== 1'b0) begin bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
        total++; if (seed_zero !== 1'b0) begin bad++; $display("FAIL reset_seed_zero: got %b want 0", seed_zero); end
        load = 1'b0; en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_first_steps();
        logic [7:0] exp_st [4];
        exp_st = '{8'h02, 8'h04, 8'h08, 8'h11};
        rst8();
        en = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            total++; if (state !== exp_st[i]) begin bad++; $display("FAIL first_state[%0d]: got %h want %h", i, state, exp_st[i]); end
            total++; if (out_valid !== (i == 3)) begin bad++; $display("FAIL first_valid[%0d]: got %b want %b", i, out_valid, i == 3); end
        end
        total++; if (out_data !== 4'h1) begin bad++; $display("FAIL first_word: got %h want 1", out_data); end
        en = 1'b0;
    endtask

    task automatic test_full_period();
        logic [7:0] ms;
        bit         seen [256];
        int         nwrap, nseen;
        rst8();
        en = 1'b1; out_ready = 1'b1;
        ms = 8'h01; nwrap = 0; nseen = 0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        for (int n = 1; n <= 510; n++) begin
            cyc();
            ms = nxt8(ms);
            total++; if (state !== ms) begin bad++; $display("FAIL period_state[%0d]: got %h want %h", n, state, ms); end
            total++; if (state === 8'h00) begin bad++; $display("FAIL period_nonzero[%0d]: got %h want nonzero", n, state); end
            total++; if (wrap !== (ms == 8'h01)) begin bad++; $display("FAIL period_wrap[%0d]: got %b want %b", n, wrap, ms == 8'h01); end
            if (wrap === 1'b1) nwrap++;
            if (n <= 255 && !seen[state]) begin seen[state] = 1'b1; nseen++; end
        end
        total++; if (nwrap != 2) begin bad++; $display("FAIL period_wrap_count: got %0d want 2", nwrap); end
        total++; if (nseen != 255) begin bad++; $display("FAIL period_visited: got %0d want 255", nseen); end
        en = 1'b0;
    endtask

    task automatic test_backpressure();
        rst8();
        en = 1'b1; out_ready = 1'b0;
        repeat (12) cyc();
        total++; if (state !== st8(8'h01, 7)) begin bad++; $display("FAIL bp_frozen_state: got %h want %h", state, st8(8'h01, 7)); end
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_valid_held: got %b want 1", out_valid); end
        total++; if (out_data !== 4'h1) begin bad++; $display("FAIL bp_data_held: got %h want 1", out_data); end
        out_ready = 1'b1;
        cyc();
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_next_valid: got %b want 1", out_valid); end
        total++; if (out_data !== word8(8'h01, 2)) begin bad++; $display("FAIL bp_next_word: got %h want %h", out_data, word8(8'h01, 2)); end
        total++; if (state !== st8(8'h01, 8)) begin bad++; $display("FAIL bp_next_state: got %h want %h", state, st8(8'h01, 8)); end
        repeat (6) cyc();
        total++; if (state !== st8(8'h01, 11)) begin bad++; $display("FAIL bp_refreeze_state: got %h want %h", state, st8(8'h01, 11)); end
        total++; if (out_data !== word8(8'h01, 2)) begin bad++; $display("FAIL bp_refreeze_data: got %h want %h", out_data, word8(8'h01, 2)); end
        out_ready = 1'b1;
        cyc();
        total++; if (out_data !== word8(8'h01, 3)) begin bad++; $display("FAIL bp_third_word: got %h want %h", out_data, word8(8'h01, 3)); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_zero_seed();
        int  n;
        bit  found;
        rst8();
        load = 1'b1; seed_in = 8'h00;
        cyc();
        load = 1'b0;
        total++; if (state !== 8'h01) begin bad++; $display("FAIL zero_state: got %h want 01", state); end
        total++; if (seed_zero !== 1'b1) begin bad++; $display("FAIL zero_pulse: got %b want 1", seed_zero); end
        cyc();
        total++; if (seed_zero !== 1'b0) begin bad++; $display("FAIL zero_pulse_end: got %b want 0", seed_zero); end
        load = 1'b1; seed_in = 8'hA5;
        cyc();
        load = 1'b0;
        total++; if (state !== 8'hA5) begin bad++; $display("FAIL loadA5_state: got %h want a5", state); end
        total++; if (seed_zero !== 1'b0) begin bad++; $display("FAIL loadA5_no_pulse: got %b want 0", seed_zero); end
        en = 1'b1; out_ready = 1'b1;
        n = 0; found = 1'b0;
        while (n < 300 && !found) begin
            cyc();
            n++;
            if (wrap === 1'b1) found = 1'b1;
        end
        total++; if (!found || n != 255) begin bad++; $display("FAIL loadA5_wrap_step: got %0d (found=%0d) want 255", n, found); end
        total++; if (state !== 8'hA5) begin bad++; $display("FAIL loadA5_wrap_state: got %h want a5", state); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_load_mid_word();
        rst8();
        en = 1'b1; out_ready = 1'b0;
        repeat (6) cyc();
        total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL mid_pre_valid: got %b want 1", out_valid); end
        total++; if (state !== st8(8'h01, 6)) begin bad++; $display("FAIL mid_pre_state: got %h want %h", state, st8(8'h01, 6)); end
        load = 1'b1; seed_in = 8'h3C;
        cyc();
        load = 1'b0; out_ready = 1'b1;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid_drop: got %b want 0", out_valid); end
        total++; if (state !== 8'h3C) begin bad++; $display("FAIL mid_state: got %h want 3c", state); end
        for (int i = 1; i <= 4; i++) begin
            cyc();
            total++; if (out_valid !== (i == 4)) begin bad++; $display("FAIL mid_word_valid[%0d]: got %b want %b", i, out_valid, i == 4); end
        end
        total++; if (out_data !== word8(8'h3C, 1)) begin bad++; $display("FAIL mid_word: got %h want %h", out_data, word8(8'h3C, 1)); end
        total++; if (state !== st8(8'h3C, 4)) begin bad++; $display("FAIL mid_word_state: got %h want %h", state, st8(8'h3C, 4)); end
        en = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ms, mseed;
        bit         q [$];
        logic       mvalid, ewrap, esz, stall;
        logic [3:0] mdata;
        rst8();
        ms = 8'h01; mseed = 8'h01; mvalid = 1'b0; mdata = 4'h0;
        q.delete();
        for (int n = 0; n < 600; n++) begin
            en        = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 1) != 0);
            load      = ($urandom_range(0, 31) == 0);
            seed_in   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
            ewrap = 1'b0; esz = 1'b0;
            if (load) begin
                ms = (seed_in == 8'h00) ? 8'h01 : seed_in;
                mseed = ms;
                q.delete();
                mvalid = 1'b0;
                esz = (seed_in == 8'h00);
            end else begin
                stall = (q.size() == 3) && mvalid && !out_ready;
                if (mvalid && out_ready) mvalid = 1'b0;
                if (en && !stall) begin
                    ms = nxt8(ms);
                    ewrap = (ms == mseed);
                    q.push_back(ms[0]);
                    if (q.size() == 4) begin
                        mdata = {q[0], q[1], q[2], q[3]};
                        mvalid = 1'b1;
                        q.delete();
                    end
                end
            end
            cyc();
            total++; if (state !== ms) begin bad++; $display("FAIL rnd_state[%0d]: got %h want %h", n, state, ms); end
            total++; if (out_valid !== mvalid) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want %b", n, out_valid, mvalid); end
            total++; if (wrap !== ewrap) begin bad++; $display("FAIL rnd_wrap[%0d]: got %b want %b", n, wrap, ewrap); end
            total++; if (seed_zero !== esz) begin bad++; $display("FAIL rnd_seed_zero[%0d]: got %b want %b", n, seed_zero, esz); end
            if (mvalid) begin
                total++; if (out_data !== mdata) begin bad++; $display("FAIL rnd_data[%0d]: got %h want %h", n, out_data, mdata); end
            end
        end
        en = 1'b0; load = 1'b0; out_ready = 1'b0;
    endtask

    task automatic test_wide();
        logic [15:0] ms;
        logic [7:0]  macc;
        int          k, nwrap, first;
        cyc();
        cyc();
        rst16 = 1'b0; en16 = 1'b1; ready16 = 1'b1;
        ms = 16'h0001; macc = 8'h00; k = 0; nwrap = 0; first = 0;
        for (int n = 1; n <= 65540; n++) begin
            cyc();
            ms = nxt16(ms);
            macc = {macc[6:0], ms[0]};
            k++;
            total++; if (state16 !== ms) begin bad++; $display("FAIL w16_state[%0d]: got %h want %h", n, state16, ms); end
            total++; if (valid16 !== (k == 8)) begin bad++; $display("FAIL w16_valid[%0d]: got %b want %b", n, valid16, k == 8); end
            if (k == 8) begin
                total++; if (data16 !== macc) begin bad++; $display("FAIL w16_data[%0d]: got %h want %h", n, data16, macc); end
                k = 0;
            end
            if (wrap16 === 1'b1) begin
                nwrap++;
                if (first == 0) first = n;
            end
        end
        total++; if (nwrap != 1 || first != 65535) begin bad++; $display("FAIL w16_wrap: got count=%0d at %0d want count=1 at 65535", nwrap, first); end
        en16 = 1'b0; ready16 = 1'b0;
    endtask

    task automatic test_out_w1();
        logic [7:0] ms;
        cyc();
        cyc();
        rst1 = 1'b0; rdy1 = 1'b1;
        ms = 8'h01;
        for (int n = 0; n < 60; n++) begin
            en1 = ($urandom_range(0, 3) != 0);
            cyc();
            if (en1) ms = nxt8(ms);
            total++; if (state1 !== ms) begin bad++; $display("FAIL w1_state[%0d]: got %h want %h", n, state1, ms); end
            total++; if (valid1 !== en1) begin bad++; $display("FAIL w1_valid[%0d]: got %b want %b", n, valid1, en1); end
            if (en1) begin
                total++; if (data1 !== ms[0]) begin bad++; $display("FAIL w1_data[%0d]: got %b want %b", n, data1, ms[0]); end
            end
        end
        en1 = 1'b0;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_first_steps();
        test_full_period();
        test_backpressure();
        test_zero_seed();
        test_load_mid_word();
        test_random();
        test_out_w1();
        test_wide();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
